rom_dl_sequencer: RTL and testbench
===================================

Name: rom_dl_sequencer

Overview:
- Sequences a MiSTer ROM download (the ioctl byte stream) into up to four ROM regions inside the game core. Decodes each byte's target region and region-relative address.
- Buffers bytes in a 2-entry FIFO and hands each one to a ROM write port that acknowledges it.
- Owns the shared ROM write ports and holds the core in reset while loading, then releases it after a settling hold.
- Sits between hps_io and the game core (e.g. in front of FPGA_SOLOMON's ROM ports).

Parameters:
- R1_BASE, 25'h08000: first byte address of region 1 (region 0 starts at 0).
- R2_BASE, 25'h0C000: first byte address of region 2.
- R3_BASE, 25'h14000: first byte address of region 3.
- END_ADDR, 25'h24000: first address past region 3; addresses at or above it are out of range.
- RST_HOLD, 1024: cycles the core stays in reset after the download ends and the FIFO drains.

Ports:
- MCLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- ioctl_download  in  1  download active.
- ioctl_wr  in  1  byte strobe, one cycle per byte.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- ioctl_wait  out  1  stall request to hps_io.
- wr_ack  in  1  target write port accepted the current write.
- rom_we  out  4  one-hot write enable, one bit per region.
- rom_ad  out  17  region-relative address.
- rom_dt  out  8  write data.
- port_own  out  1  1 = loader drives the ROM ports; 0 = core owns them.
- core_rst  out  1  reset to the game core.
- dl_done  out  1  at least one download has completed and the core is running.
- err_oor  out  1  sticky: an out-of-range byte was seen.
- err_ovf  out  1  sticky: a byte arrived while the FIFO was full.
- chk_sum  out  16  checksum (see Optional Feature).

Behaviour:
- Reset (async, RESET=1): state IDLE, FIFO empty, counter 0. Outputs: rom_we=0, rom_ad=0, rom_dt=0, ioctl_wait=0, port_own=1, core_rst=1, dl_done=0, err_oor=0, err_ovf=0, chk_sum=0.
- Decode at push:
  - region = 3 if addr>=R3_BASE, else 2 if >=R2_BASE, else 1 if >=R1_BASE, else 0.
  - offset = addr minus region base, truncated to 17 bits.
  - addr>=END_ADDR: byte is discarded, not pushed; err_oor set.
- FIFO: 2 entries of {region[1:0], offset[16:0], data[7:0]}.
  - Push on ioctl_wr in LOAD or DRAIN when count<2.
  - ioctl_wr when count==2: byte dropped, err_ovf set.
  - Push and pop in the same cycle is legal; count is unchanged.
  - ioctl_wait is registered and equals (count_next>=1).
- Write issue:
  - Head entry drives rom_ad/rom_dt with rom_we[region]=1, held stable until wr_ack=1.
  - On wr_ack the entry pops; the next head appears the following cycle, so rom_we deasserts for at least one cycle between writes.
  - Latency: byte pushed in cycle N reaches rom_we in cycle N+1 when the FIFO was empty.
  - wr_ack while rom_we==0 is ignored.
- FSM:
  - IDLE: port_own=1, core_rst=1. ioctl_download=1 -> LOAD.
  - LOAD: port_own=1, core_rst=1, dl_done=0. Entry clears err_oor, err_ovf and chk_sum. ioctl_download=0 -> DRAIN.
  - DRAIN: finishes FIFO writes; counter cleared. FIFO empty and rom_we=0 -> HOLD. ioctl_download=1 -> LOAD; FIFO contents are kept, errors are not cleared.
  - HOLD: counter increments each cycle; counter==RST_HOLD-1 -> RUN. ioctl_download=1 -> LOAD.
  - RUN: port_own=0, core_rst=0, dl_done=1, rom_we=0. ioctl_download=1 -> LOAD; core_rst and port_own assert in the next cycle.
- A mid-download RESET aborts everything: FIFO flushed, state IDLE. Any partial ROM contents are reloaded by the next download.

Optional Feature:
- Macro: DL_CHECKSUM_EN.
- Defined: chk_sum accumulates the mod-2^16 sum of each byte when it is acknowledged (wr_ack). It is cleared on LOAD entry and held in RUN.
- Undefined: chk_sum is constant 0 and no accumulator logic exists.

Test Plan:
- Download of 4 bytes, addr 0x00000-0x00003, data 0x11..0x44, wr_ack tied 1:
  - rom_we=4'b0001 with rom_ad 0..3.
  - After download falls: HOLD for 1024 cycles, then core_rst=0, port_own=0, dl_done=1.
  - chk_sum=0x00AA with DL_CHECKSUM_EN.
- Bytes at 0x07FFF, 0x08000, 0x14005:
  - rom_we 0001/ad 0x7FFF, then 0010/ad 0x0000, then 1000/ad 0x0005.
  - Byte at 0x24000: no rom_we, err_oor=1.
- wr_ack held 0 for 10 cycles, 3 ioctl_wr back-to-back:
  - ioctl_wait=1 from the cycle after the first push.
  - Third byte dropped, err_ovf=1.
  - Release wr_ack: first two bytes written in order.
- ioctl_download re-asserted at HOLD count 500:
  - Returns to LOAD, core_rst stays 1.
  - Counter restarts from 0 after the next DRAIN.
- RESET pulsed during LOAD with 2 bytes queued:
  - Next cycle: rom_we=0, FIFO empty, state IDLE, core_rst=1, dl_done=0.
- From RUN, new download starts: next cycle core_rst=1, port_own=1, dl_done=0, err flags cleared.

Source files
------------

// File: rtl/rom_dl_sequencer.sv
// rom_dl_sequencer
//
// Sequences a MiSTer ioctl ROM download into up to four ROM regions of the
// game core. Each incoming byte is decoded into a region number and a
// region-relative address. It is then buffered in a 2-entry FIFO and written
// through a one-hot write port that acknowledges each write. While loading,
// the sequencer owns the ROM ports and holds the core in reset. After the
// download ends and the FIFO drains, it waits RST_HOLD cycles and then
// releases the core.
//
// Optional feature: define DL_CHECKSUM_EN to accumulate a mod-2^16 sum of the
// acknowledged bytes on chk_sum. Without it, chk_sum is tied to zero.
//
// Ports:
//   MCLK            system clock
//   RESET           asynchronous active-high reset
//   ioctl_download  download active (from hps_io)
//   ioctl_wr        one-cycle byte strobe
//   ioctl_addr      byte address [24:0]
//   ioctl_dout      byte data [7:0]
//   ioctl_wait      stall request to hps_io (registered)
//   wr_ack          target write port accepted the current write
//   rom_we          one-hot write enable, one bit per region [3:0]
//   rom_ad          region-relative address [16:0]
//   rom_dt          write data [7:0]
//   port_own        1 = loader drives the ROM ports, 0 = core owns them
//   core_rst        reset to the game core
//   dl_done         a download has completed and the core is running
//   err_oor         sticky: out-of-range byte seen
//   err_ovf         sticky: byte arrived while the FIFO was full
//   chk_sum         byte checksum (zero unless DL_CHECKSUM_EN)
module rom_dl_sequencer #(
    parameter logic [24:0] R1_BASE  = 25'h08000,
    parameter logic [24:0] R2_BASE  = 25'h0C000,
    parameter logic [24:0] R3_BASE  = 25'h14000,
    parameter logic [24:0] END_ADDR = 25'h24000,
    parameter int unsigned RST_HOLD = 1024
) (
    input  logic        MCLK,
    input  logic        RESET,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    input  logic        wr_ack,
    output logic [3:0]  rom_we,
    output logic [16:0] rom_ad,
    output logic [7:0]  rom_dt,
    output logic        port_own,
    output logic        core_rst,
    output logic        dl_done,
    output logic        err_oor,
    output logic        err_ovf,
    output logic [15:0] chk_sum
);

    localparam int unsigned CW = $clog2(RST_HOLD + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_HOLD,
        S_RUN
    } state_t;

    state_t         state, state_next;

    // FIFO entry layout: {region[1:0], offset[16:0], data[7:0]}
    logic [26:0]    fifo_mem [2];
    logic           wr_ptr, rd_ptr;
    logic [1:0]     count, count_next;
    logic [26:0]    head;
    logic           gap;
    logic [CW-1:0]  hold_cnt;

    logic [1:0]     dec_region;
    logic [24:0]    dec_base;
    logic [16:0]    dec_offset;
    logic           accepting, in_range, push, pop, we_active, load_entry;

    // Region decode of the incoming byte
    always_comb begin
        dec_region = 2'd0;
        dec_base   = '0;
        if (ioctl_addr >= R3_BASE) begin
            dec_region = 2'd3;
            dec_base   = R3_BASE;
        end else if (ioctl_addr >= R2_BASE) begin
            dec_region = 2'd2;
            dec_base   = R2_BASE;
        end else if (ioctl_addr >= R1_BASE) begin
            dec_region = 2'd1;
            dec_base   = R1_BASE;
        end
        dec_offset = 17'(ioctl_addr - dec_base);
    end

    assign accepting = (state == S_LOAD) || (state == S_DRAIN);
    assign in_range  = (ioctl_addr < END_ADDR);
    assign push      = accepting && ioctl_wr && in_range && (count != 2'd2);

    // gap forces one idle cycle after every acknowledged write so that the
    // next head is presented on a fresh rom_we assertion
    assign head      = fifo_mem[rd_ptr];
    assign we_active = (count != 2'd0) && !gap;
    assign pop       = we_active && wr_ack;

    always_comb begin
        rom_we = '0;
        if (we_active) begin
            rom_we = 4'b0001 << head[26:25];
        end
        rom_ad = head[24:8];
        rom_dt = head[7:0];
    end

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 2'd1;
        end else if (pop && !push) begin
            count_next = count - 2'd1;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (ioctl_download) state_next = S_LOAD;
            end
            S_LOAD: begin
                if (!ioctl_download) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (ioctl_download)          state_next = S_LOAD;
                else if (count == 2'd0)      state_next = S_HOLD;
            end
            S_HOLD: begin
                if (ioctl_download)                      state_next = S_LOAD;
                else if (hold_cnt == CW'(RST_HOLD - 1))  state_next = S_RUN;
            end
            S_RUN: begin
                if (ioctl_download) state_next = S_LOAD;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Re-entering LOAD from DRAIN continues the same download, so only a
    // fresh entry clears the error flags and checksum
    assign load_entry = (state_next == S_LOAD) && !accepting;

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            state       <= S_IDLE;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
            gap         <= 1'b0;
            hold_cnt    <= '0;
            ioctl_wait  <= 1'b0;
            port_own    <= 1'b1;
            core_rst    <= 1'b1;
            dl_done     <= 1'b0;
            err_oor     <= 1'b0;
            err_ovf     <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            gap   <= pop;

            if (push) begin
                fifo_mem[wr_ptr] <= {dec_region, dec_offset, ioctl_dout};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end

            if (state == S_HOLD && state_next == S_HOLD) begin
                hold_cnt <= hold_cnt + CW'(1);
            end else begin
                hold_cnt <= '0;
            end

            ioctl_wait <= (count_next != 2'd0);
            port_own   <= (state_next != S_RUN);
            core_rst   <= (state_next != S_RUN);
            dl_done    <= (state_next == S_RUN);

            if (load_entry) begin
                err_oor <= 1'b0;
                err_ovf <= 1'b0;
            end else if (accepting && ioctl_wr) begin
                if (!in_range) begin
                    err_oor <= 1'b1;
                end else if (count == 2'd2) begin
                    err_ovf <= 1'b1;
                end
            end
        end
    end

`ifdef DL_CHECKSUM_EN
    logic [15:0] chk_acc;

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            chk_acc <= '0;
        end else if (load_entry) begin
            chk_acc <= '0;
        end else if (pop) begin
            chk_acc <= chk_acc + {8'h00, head[7:0]};
        end
    end

    assign chk_sum = chk_acc;
`else
    assign chk_sum = '0;
`endif

endmodule

// File: tb/tb_rom_dl_sequencer.sv
module tb_rom_dl_sequencer;

    logic        MCLK = 1'b0;
    logic        RESET = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        ioctl_wait;
    logic        wr_ack = 1'b1;
    logic [3:0]  rom_we;
    logic [16:0] rom_ad;
    logic [7:0]  rom_dt;
    logic        port_own;
    logic        core_rst;
    logic        dl_done;
    logic        err_oor;
    logic        err_ovf;
    logic [15:0] chk_sum;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0]  we;
        logic [16:0] ad;
        logic [7:0]  dt;
    } wr_t;

    wr_t         exp_q[$];
    logic [15:0] exp_sum = '0;

    always #5 MCLK = ~MCLK;

    rom_dl_sequencer dut (
        .MCLK           (MCLK),
        .RESET          (RESET),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .wr_ack         (wr_ack),
        .rom_we         (rom_we),
        .rom_ad         (rom_ad),
        .rom_dt         (rom_dt),
        .port_own       (port_own),
        .core_rst       (core_rst),
        .dl_done        (dl_done),
        .err_oor        (err_oor),
        .err_ovf        (err_ovf),
        .chk_sum        (chk_sum)
    );

    // Expected write for an in-range byte, from the default region map
    function automatic wr_t model_write(input logic [24:0] a, input logic [7:0] d);
        wr_t w;
        logic [24:0] base;
        if (a >= 25'h14000) begin
            w.we = 4'b1000; base = 25'h14000;
        end else if (a >= 25'h0C000) begin
            w.we = 4'b0100; base = 25'h0C000;
        end else if (a >= 25'h08000) begin
            w.we = 4'b0010; base = 25'h08000;
        end else begin
            w.we = 4'b0001; base = 25'h00000;
        end
        w.ad = 17'(a - base);
        w.dt = d;
        return w;
    endfunction

    // Scoreboard: every acknowledged write is compared against the queue
    always @(negedge MCLK) begin : monitor
        wr_t got;
        wr_t want;
        if (!RESET && rom_we != 4'b0000 && wr_ack) begin
            got = {rom_we, rom_ad, rom_dt};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_write got we=%b ad=%h dt=%h required no write",
                         rom_we, rom_ad, rom_dt);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL sb_write got we=%b ad=%h dt=%h required we=%b ad=%h dt=%h",
                             got.we, got.ad, got.dt, want.we, want.ad, want.dt);
                end
            end
            exp_sum = exp_sum + {8'h00, rom_dt};
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge MCLK);
        #1;
    endtask

    // hps_io-style byte send: honours ioctl_wait
    task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
        int unsigned n = 0;
        while (ioctl_wait && n < 200) begin
            tick();
            n++;
        end
        if (ioctl_wait) begin
            checks++; errors++;
            $display("FAIL wait_timeout got ioctl_wait=1 required 0 within 200 cycles");
        end
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        if (a < 25'h24000) exp_q.push_back(model_write(a, d));
        tick();
        ioctl_wr = 1'b0;
    endtask

    task automatic wait_drain();
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout got %0d pending required 0", exp_q.size());
            exp_q.delete();
        end
        tick();
    endtask

    // Drops download and counts cycles until core_rst releases
    task automatic run_release(input string name);
        int k = 0;
        ioctl_download = 1'b0;
        while (core_rst && k < 1100) begin
            tick();
            k++;
        end
        checks++;
        if (k !== 1026) begin
            errors++;
            $display("FAIL %s_release_cycles got %0d required 1026", name, k);
        end
    endtask

    task automatic check_chk(input string name, input logic [15:0] want);
        logic [15:0] req;
`ifdef DL_CHECKSUM_EN
        req = want;
`else
        req = 16'h0000;
`endif
        checks++;
        if (chk_sum !== req) begin
            errors++;
            $display("FAIL %s got %h required %h", name, chk_sum, req);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) tick();
        checks++;
        if ({rom_we, rom_ad, rom_dt, ioctl_wait} !== '0) begin
            errors++;
            $display("FAIL reset_ports got we=%b ad=%h dt=%h wait=%b required all 0",
                     rom_we, rom_ad, rom_dt, ioctl_wait);
        end
        checks++;
        if ({port_own, core_rst, dl_done, err_oor, err_ovf} !== 5'b11000) begin
            errors++;
            $display("FAIL reset_ctrl got %b required 11000",
                     {port_own, core_rst, dl_done, err_oor, err_ovf});
        end
        checks++;
        if (chk_sum !== 16'h0000) begin
            errors++;
            $display("FAIL reset_chk got %h required 0000", chk_sum);
        end
        RESET = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        ioctl_download = 1'b1;
        exp_sum = '0;
        tick();
        for (int i = 0; i < 4; i++) begin
            send_byte(25'(i), 8'(8'h11 * (i + 1)));
        end
        wait_drain();
        run_release("basic");
        checks++;
        if ({port_own, core_rst, dl_done} !== 3'b001) begin
            errors++;
            $display("FAIL basic_run got own/rst/done=%b required 001",
                     {port_own, core_rst, dl_done});
        end
        check_chk("basic_chk", 16'h00AA);
        checks++;
        if (exp_sum !== 16'h00AA) begin
            errors++;
            $display("FAIL basic_acked_sum got %h required 00AA", exp_sum);
        end
    endtask

    task automatic test_regions();
        ioctl_download = 1'b1;
        exp_sum = '0;
        tick();
        send_byte(25'h07FFF, 8'h5A);
        send_byte(25'h08000, 8'h6B);
        send_byte(25'h14005, 8'h7C);
        send_byte(25'h24000, 8'h8D);
        wait_drain();
        checks++;
        if ({err_oor, err_ovf} !== 2'b10) begin
            errors++;
            $display("FAIL regions_err got oor/ovf=%b required 10", {err_oor, err_ovf});
        end
    endtask

    task automatic test_overflow();
        logic w1;
        logic stable = 1'b1;
        wr_ack = 1'b0;
        ioctl_addr = 25'h00100; ioctl_dout = 8'hA1; ioctl_wr = 1'b1;
        exp_q.push_back(model_write(25'h00100, 8'hA1));
        tick();
        w1 = ioctl_wait;
        ioctl_addr = 25'h00101; ioctl_dout = 8'hA2;
        exp_q.push_back(model_write(25'h00101, 8'hA2));
        tick();
        ioctl_addr = 25'h00102; ioctl_dout = 8'hA3;
        tick();
        ioctl_wr = 1'b0;
        checks++;
        if (w1 !== 1'b1) begin
            errors++;
            $display("FAIL ovf_wait got %b required 1", w1);
        end
        checks++;
        if (err_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag got %b required 1", err_ovf);
        end
        for (int i = 0; i < 7; i++) begin
            if (rom_we !== 4'b0001 || rom_ad !== 17'h00100 || rom_dt !== 8'hA1) stable = 1'b0;
            tick();
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL ovf_hold got we=%b ad=%h dt=%h required 0001/00100/a1",
                     rom_we, rom_ad, rom_dt);
        end
        wr_ack = 1'b1;
        wait_drain();
        checks++;
        if (ioctl_wait !== 1'b0) begin
            errors++;
            $display("FAIL ovf_wait_clear got %b required 0", ioctl_wait);
        end
    endtask

    task automatic test_hold_restart();
        logic rst_ok = 1'b1;
        ioctl_download = 1'b0;
        for (int i = 0; i < 502; i++) begin
            tick();
            if (core_rst !== 1'b1) rst_ok = 1'b0;
        end
        ioctl_download = 1'b1;
        exp_sum = '0;
        tick();
        if (core_rst !== 1'b1) rst_ok = 1'b0;
        checks++;
        if (!rst_ok) begin
            errors++;
            $display("FAIL hold_core_rst got 0 required 1 throughout");
        end
        checks++;
        if ({err_oor, err_ovf} !== 2'b00) begin
            errors++;
            $display("FAIL hold_reload_err got %b required 00", {err_oor, err_ovf});
        end
        send_byte(25'h0030000, 8'hEE);
        run_release("hold_restart");
        checks++;
        if ({dl_done, err_oor} !== 2'b11) begin
            errors++;
            $display("FAIL hold_run got done/oor=%b required 11", {dl_done, err_oor});
        end
        check_chk("hold_chk", exp_sum);
    endtask

    task automatic test_run_restart();
        ioctl_download = 1'b1;
        exp_sum = '0;
        tick();
        checks++;
        if ({port_own, core_rst, dl_done, err_oor, err_ovf} !== 5'b11000) begin
            errors++;
            $display("FAIL restart got own/rst/done/oor/ovf=%b required 11000",
                     {port_own, core_rst, dl_done, err_oor, err_ovf});
        end
        check_chk("restart_chk", 16'h0000);
    endtask

    task automatic test_reset_mid_load();
        logic quiet = 1'b1;
        wr_ack = 1'b0;
        ioctl_addr = 25'h00010; ioctl_dout = 8'h01; ioctl_wr = 1'b1;
        tick();
        ioctl_addr = 25'h00011; ioctl_dout = 8'h02;
        tick();
        ioctl_wr = 1'b0;
        checks++;
        if (rom_we !== 4'b0001) begin
            errors++;
            $display("FAIL midrst_pre got we=%b required 0001", rom_we);
        end
        RESET = 1'b1;
        ioctl_download = 1'b0;
        tick();
        RESET = 1'b0;
        checks++;
        if ({rom_we, ioctl_wait, port_own, core_rst, dl_done} !== 8'b0000_0110) begin
            errors++;
            $display("FAIL midrst got we=%b wait=%b own/rst/done=%b required 0000 0 110",
                     rom_we, ioctl_wait, {port_own, core_rst, dl_done});
        end
        wr_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rom_we !== 4'b0000 || ioctl_wait !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL midrst_flushed got activity required empty FIFO");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_regions();
        test_overflow();
        test_hold_restart();
        test_run_restart();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
